// File: rtl/vec_pkg.sv
// Shared definitions for the vector element sequencer: default widths and FSM state encoding.
package vec_pkg;

  localparam int VEC_AW   = 16;
  localparam int VEC_DW   = 16;
  localparam int VEC_LENW = 8;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    EXEC = 3'd3,
    WR_D = 3'd4,
    DONE = 3'd5
  } state_t;

endpackage

// File: rtl/vec_ptr_ctr.sv
// Loadable address pointer: loads a base address, then advances by a step (wraps modulo 2^AW).
module vec_ptr_ctr
  import vec_pkg::*;
#(
  parameter int AW = VEC_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          inc,
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] step,
  output logic [AW-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (load) begin
      ptr <= base;
    end else if (inc) begin
      ptr <= ptr + step;
    end
  end

endmodule

// File: rtl/vec_elem_sequencer.sv
// Memory-to-memory vector element sequencer: D[i] = ALU(A[i], B[i]) at 4 cycles per element.
// Optional feature macro VSEQ_STRIDE_EN: element step taken from the stride port instead of 1.
module vec_elem_sequencer
  import vec_pkg::*;
#(
  parameter int AW   = VEC_AW,
  parameter int DW   = VEC_DW,
  parameter int LENW = VEC_LENW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [AW-1:0]   base_a,
  input  logic [AW-1:0]   base_b,
  input  logic [AW-1:0]   base_d,
  input  logic [LENW-1:0] vlen,
  input  logic [AW-1:0]   stride,
  input  logic [DW-1:0]   mem_rdata,
  input  logic [DW-1:0]   alu_result,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_we,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW-1:0]   op_a,
  output logic [DW-1:0]   op_b,
  output logic            addr_sel,
  output logic            busy,
  output logic            done
);

  state_t          state, state_nx;
  logic [LENW-1:0] cnt, vlen_q;
  logic [AW-1:0]   step;
  logic [AW-1:0]   ptr_a, ptr_b, ptr_d;
  logic            accept, adv, last;

  assign accept = (state == IDLE) && start && (vlen != '0);
  assign adv    = (state == WR_D);
  assign last   = (cnt == vlen_q - LENW'(1));

`ifdef VSEQ_STRIDE_EN
  logic [AW-1:0] stride_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stride_q <= '0;
    end else if (accept) begin
      stride_q <= stride;
    end
  end

  assign step = stride_q;
`else
  logic stride_unused;

  assign stride_unused = ^stride;
  assign step          = AW'(1);
`endif

  vec_ptr_ctr #(.AW(AW)) u_ptr_a (
    .clk(clk), .reset(reset), .load(accept), .inc(adv), .base(base_a), .step(step), .ptr(ptr_a)
  );
  vec_ptr_ctr #(.AW(AW)) u_ptr_b (
    .clk(clk), .reset(reset), .load(accept), .inc(adv), .base(base_b), .step(step), .ptr(ptr_b)
  );
  vec_ptr_ctr #(.AW(AW)) u_ptr_d (
    .clk(clk), .reset(reset), .load(accept), .inc(adv), .base(base_d), .step(step), .ptr(ptr_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Read data arrives one cycle after its address, so A lands during RD_B and B during EXEC.
  always_comb begin
    state_nx  = state;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    addr_sel  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = (vlen != '0) ? RD_A : DONE;
        end
      end
      RD_A: begin
        mem_addr = ptr_a;
        busy     = 1'b1;
        state_nx = RD_B;
      end
      RD_B: begin
        mem_addr = ptr_b;
        busy     = 1'b1;
        state_nx = EXEC;
      end
      EXEC: begin
        mem_addr = ptr_b;
        busy     = 1'b1;
        state_nx = WR_D;
      end
      WR_D: begin
        mem_addr  = ptr_d;
        addr_sel  = 1'b1;
        mem_we    = 1'b1;
        mem_wdata = alu_result;
        busy      = 1'b1;
        state_nx  = last ? DONE : RD_A;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      vlen_q <= '0;
      op_a   <= '0;
      op_b   <= '0;
    end else begin
      if (accept) begin
        vlen_q <= vlen;
        cnt    <= '0;
      end else if (adv && !last) begin
        cnt <= cnt + LENW'(1);
      end
      if (state == RD_B) begin
        op_a <= mem_rdata;
      end
      if (state == EXEC) begin
        op_b <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_vec_elem_sequencer.sv
// Scoreboard bench for vec_elem_sequencer: behavioural memory plus adder ALU, expected writes queued.
module tb_vec_elem_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] base_a, base_b, base_d, stride;
  logic [7:0]  vlen;
  logic [15:0] mem_rdata, alu_result;
  logic [15:0] mem_addr, mem_wdata, op_a, op_b;
  logic        mem_we, addr_sel, busy, done;

  logic [15:0] mem [0:65535];
  logic [31:0] sb_q [$];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  vec_elem_sequencer dut (
    .clk(clk), .reset(reset), .start(start),
    .base_a(base_a), .base_b(base_b), .base_d(base_d),
    .vlen(vlen), .stride(stride),
    .mem_rdata(mem_rdata), .alu_result(alu_result),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .op_a(op_a), .op_b(op_b), .addr_sel(addr_sel),
    .busy(busy), .done(done)
  );

  assign alu_result = op_a + op_b;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Every write strobe must match the oldest queued {addr, data}.
  always @(negedge clk) begin
    if (mem_we) begin
      if (sb_q.size() == 0) begin
        check("spurious_we", 32'(mem_we), 32'd0);
      end else begin
        logic [31:0] e;
        e = sb_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(e[31:16]));
        check("wr_data", 32'(mem_wdata), 32'(e[15:0]));
        check("wr_sel", 32'(addr_sel), 32'd1);
      end
    end
  end

  task automatic run_op(input logic [15:0] ba, input logic [15:0] bb, input logic [15:0] bd,
                        input logic [7:0] vl, input logic [15:0] st,
                        input int glitch_k, input int abort_k);
    logic [15:0] stp;
    logic [15:0] ea, eb;
    int          n_push;
    int          exp_k;
    bit          seen;
`ifdef VSEQ_STRIDE_EN
    stp = st;
`else
    stp = 16'd1;
`endif
    n_push = (abort_k == 0) ? int'(vl) : ((abort_k - 1) / 4) + 1;
    for (int i = 0; i < n_push; i++) begin
      ea = ba + 16'(i) * stp;
      eb = bb + 16'(i) * stp;
      sb_q.push_back({bd + 16'(i) * stp, 16'(mem[ea] + mem[eb])});
    end
    exp_k = 4 * int'(vl) + 1;
    seen  = 1'b0;
    @(negedge clk);
    base_a = ba; base_b = bb; base_d = bd; vlen = vl; stride = st; start = 1'b1;
    for (int k = 1; k <= 4 * int'(vl) + 6; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (glitch_k != 0 && k == glitch_k) begin
        start = 1'b1; base_a = 16'hAAAA; base_d = 16'h5555; vlen = 8'd9;
      end else if (glitch_k != 0 && k == glitch_k + 1) begin
        start = 1'b0; base_a = ba; base_d = bd; vlen = vl;
      end
      if (abort_k != 0 && k == abort_k + 1) begin
        reset = 1'b0;
        check("abort_we", 32'(mem_we), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
      end
      if ((abort_k == 0 || k <= abort_k) && k <= 4 * int'(vl) && ((k - 1) % 4) == 0) begin
        check("rd_a_addr", 32'(mem_addr), 32'(ba + 16'((k - 1) / 4) * stp));
        check("busy_run", 32'(busy), 32'd1);
      end
      if (vl == 8'd0 && k == 1) check("busy_len0", 32'(busy), 32'd0);
      if (done && !seen) begin
        seen = 1'b1;
        check("done_latency", 32'(k), 32'(exp_k));
        check("busy_at_done", 32'(busy), 32'd0);
      end
      if (abort_k != 0 && k == abort_k) reset = 1'b1;
    end
    check("done_seen", 32'(seen), (abort_k == 0) ? 32'd1 : 32'd0);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    base_a = '0; base_b = '0; base_d = '0; vlen = '0; stride = '0;
    for (int i = 0; i < 8; i++) begin
      mem[16'h0100 + 16'(i)] = 16'(i + 1);
      mem[16'h0200 + 16'(i) * 16'd1] = 16'(10 * (i + 1));
      mem[16'h0010 + 16'(i)] = 16'h0700 + 16'(i);
      mem[16'h0020 + 16'(i)] = 16'h0030 + 16'(3 * i);
    end
    for (int i = 8; i < 32; i++) begin
      mem[16'h0010 + 16'(i)] = 16'h0700 + 16'(i);
      mem[16'h0020 + 16'(i)] = 16'h0030 + 16'(3 * i);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_op_a", 32'(op_a), 32'd0);
    check("rst_op_b", 32'(op_b), 32'd0);
    check("rst_sel", 32'(addr_sel), 32'd0);
    reset = 1'b0;

    // Basic add over three elements.
    run_op(16'h0100, 16'h0200, 16'h0300, 8'd3, 16'd1, 0, 0);
    check("mem_d0", 32'(mem[16'h0300]), 32'd11);
    check("mem_d1", 32'(mem[16'h0301]), 32'd22);
    check("mem_d2", 32'(mem[16'h0302]), 32'd33);

    // Zero-length vector.
    run_op(16'h0100, 16'h0200, 16'h0400, 8'd0, 16'd1, 0, 0);

    // Strided operands.
    run_op(16'h0010, 16'h0020, 16'h0500, 8'd2, 16'd4, 0, 0);

    // Destination wrap past 0xFFFF.
    run_op(16'h0100, 16'h0200, 16'hFFFF, 8'd2, 16'd1, 0, 0);

    // Reset during WR_D of element 1 of 4.
    run_op(16'h0100, 16'h0200, 16'h0600, 8'd4, 16'd1, 0, 8);

    // Start re-pulsed while busy.
    run_op(16'h0102, 16'h0203, 16'h0700, 8'd2, 16'd1, 3, 0);

    repeat (3) @(negedge clk);
    check("idle_we", 32'(mem_we), 32'd0);
    check("idle_done", 32'(done), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
